// File: rtl/nubus_master_seq.sv
// ============================================================================
//  Module   : nubus_master_seq
//  Purpose  : NuBus master-path sequencer. Requests the bus for the internal
//             master engine, runs the arbitration window, issues one START
//             per transfer, waits for ACK and releases ownership fairly.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module nubus_master_seq #(
  parameter int ARB_CYCLES = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic nub_clkn,
  input  logic nub_resetn,
  input  logic mst_req,
  input  logic mst_lock,
  input  logic tx_go,
  input  logic grant,
  input  logic start_n_in,
  input  logic ack_n_in,
  input  logic rqst_n_in,
  output logic rqst_n_out,
  output logic rqst_oe_n,
  output logic arbcy_n,
  output logic start_n_out,
  output logic nubus_master_dir,
  output logic bus_owner,
  output logic tx_done,
  output logic tx_err
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FAIRWAIT = 4'd1;
  localparam logic [3:0] S_REQ      = 4'd2;
  localparam logic [3:0] S_ARB      = 4'd3;
  localparam logic [3:0] S_CHECK    = 4'd4;
  localparam logic [3:0] S_OWN      = 4'd5;
  localparam logic [3:0] S_START    = 4'd6;
  localparam logic [3:0] S_WAITACK  = 4'd7;
  localparam logic [3:0] S_DONE     = 4'd8;

  localparam logic [15:0] C_ARB_LOAD = 16'(ARB_CYCLES - 1);
  localparam logic [15:0] C_TMO_LOAD = 16'(TIMEOUT);

  logic [3:0]  r_state;
  logic [3:0]  w_next;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt;
  logic        r_busy;
  logic        w_tmo;

  // Next-cycle values of the registered outputs.
  logic w_rqst_n;
  logic w_arbcy_n;
  logic w_start_n;
  logic w_own;
  logic w_done;
  logic w_err;

  logic r_rqst_n;
  logic r_arbcy_n;
  logic r_start_n;
  logic r_own;
  logic r_done;
  logic r_err;

  // Bus activity tracker: START opens a transaction, ACK closes it; a
  // simultaneous START and ACK means a new transaction began, so busy stays 1.
  always_ff @(posedge nub_clkn) begin
    if (!nub_resetn) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= !start_n_in || (r_busy && ack_n_in);
    end
  end

  // State, shared counter and registered outputs.
  always_ff @(posedge nub_clkn) begin
    if (!nub_resetn) begin
      r_state   <= S_IDLE;
      r_cnt     <= 16'd0;
      r_rqst_n  <= 1'b1;
      r_arbcy_n <= 1'b1;
      r_start_n <= 1'b1;
      r_own     <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= w_cnt;
      r_rqst_n  <= w_rqst_n;
      r_arbcy_n <= w_arbcy_n;
      r_start_n <= w_start_n;
      r_own     <= w_own;
      r_done    <= w_done;
      r_err     <= w_err;
    end
  end

  // Next-state logic. One counter serves both the arbitration window and the
  // ACK timeout; the timeout is loaded on the edge entering START so that the
  // abort lands TIMEOUT+1 cycles after the START cycle.
  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt;
    w_tmo  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mst_req) w_next = S_REQ;
      end
      S_REQ: begin
        if (!mst_req) begin
          w_next = S_FAIRWAIT;
        end else if (!r_busy || !ack_n_in) begin
          w_next = S_ARB;
          w_cnt  = C_ARB_LOAD;
        end
      end
      S_ARB: begin
        if (!mst_req) begin
          w_next = S_FAIRWAIT;
        end else if (r_cnt == 16'd0) begin
          w_next = S_CHECK;
        end else begin
          w_cnt = r_cnt - 16'd1;
        end
      end
      S_CHECK: begin
        if (!mst_req) begin
          w_next = S_FAIRWAIT;
        end else if (grant) begin
          w_next = S_OWN;
        end else begin
          w_next = S_REQ;
        end
      end
      S_OWN: begin
        if (tx_go) begin
          w_next = S_START;
          w_cnt  = C_TMO_LOAD;
        end else if (!mst_req) begin
          w_next = S_FAIRWAIT;
        end
      end
      S_START: begin
        w_next = S_WAITACK;
        if (r_cnt != 16'd0) w_cnt = r_cnt - 16'd1;
      end
      S_WAITACK: begin
        if (!ack_n_in) begin
          w_next = S_DONE;
        end else if (r_cnt == 16'd0) begin
          w_next = S_FAIRWAIT;
          w_tmo  = 1'b1;
        end else begin
          w_cnt = r_cnt - 16'd1;
        end
      end
      S_DONE: begin
        if (mst_lock && mst_req) begin
          w_next = S_OWN;
        end else begin
          w_next = S_FAIRWAIT;
        end
      end
      S_FAIRWAIT: begin
        if (rqst_n_in) w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Output decode from the state being entered. DONE keeps ownership and
  // master direction so a locked back-to-back transfer sees no gap.
  always_comb begin
    w_rqst_n  = 1'b1;
    w_arbcy_n = 1'b1;
    w_start_n = 1'b1;
    w_own     = 1'b0;
    w_done    = 1'b0;
    w_err     = w_tmo;
    case (w_next)
      S_REQ:     w_rqst_n = 1'b0;
      S_ARB,
      S_CHECK: begin
        w_rqst_n  = 1'b0;
        w_arbcy_n = 1'b0;
      end
      S_OWN: begin
        w_rqst_n = 1'b0;
        w_own    = 1'b1;
      end
      S_START: begin
        w_start_n = 1'b0;
        w_own     = 1'b1;
      end
      S_WAITACK: w_own = 1'b1;
      S_DONE: begin
        w_own  = 1'b1;
        w_done = (r_state == S_WAITACK);
      end
      default: begin
        w_rqst_n = 1'b1;
      end
    endcase
  end

  assign rqst_n_out       = r_rqst_n;
  assign rqst_oe_n        = r_rqst_n;
  assign arbcy_n          = r_arbcy_n;
  assign start_n_out      = r_start_n;
  assign nubus_master_dir = r_own;
  assign bus_owner        = r_own;
  assign tx_done          = r_done;
  assign tx_err           = r_err;

endmodule

`default_nettype wire
